cache_mem_arbiter: RTL and testbench

- Shares the single physical memory port (pmem_*) between the instruction cache and the data cache.
- Sits between the two caches and the cacheline adaptor / physical memory in the mp3 top.
- One outstanding line transaction at a time: the grant is latched for the whole burst and the response is routed back to the owner.
- I-side is read-only; D-side is read or write (writeback).

---
 rtl/cache_mem_arbiter_pkg.sv | 19 +
 rtl/cache_mem_arbiter_chk.sv | 20 ++
 rtl/cache_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared mp3 memory-arbiter types: arbiter state, grant owner and line/address widths.
// The caches import the same width constants so the pmem buses line up.
package cache_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_chk.sv
// Protocol checker for cache_mem_arbiter: an illegal D-side read+write request
// and a response routed to both caches at once are both flagged.
module cache_mem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_pmem_read,
  input logic d_pmem_write,
  input logic i_pmem_resp,
  input logic d_pmem_resp
);

  // The D cache must never ask for a read and a writeback in the same cycle
  d_rw_exclusive_a: assert property (@(posedge clk) disable iff (!rst)
    !(d_pmem_read && d_pmem_write));

  // A completion belongs to exactly one owner
  resp_onehot_a: assert property (@(posedge clk) disable iff (!rst)
    !(i_pmem_resp && d_pmem_resp));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single pmem port between the I-cache and D-cache, one line burst at a time.
// Define CACHE_ARB_RR_EN for round-robin priority on contested grants; otherwise D wins over I.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_r;
  arb_owner_t last_owner_s;
  arb_owner_t winner_s;
  logic       i_req_s;
  logic       d_req_s;

  // Fixed D-over-I priority is the round-robin rule with the last owner pinned to I
  function automatic arb_owner_t pick_owner(input logic i_req, input logic d_req,
                                            input arb_owner_t last);
    arb_owner_t w;
    if (d_req && i_req) begin
      w = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      w = OWN_D;
    end else begin
      w = OWN_I;
    end
    return w;
  endfunction

`ifdef CACHE_ARB_RR_EN
  arb_owner_t last_owner_r;

  // Remember who held the previous grant so a contested request alternates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_r <= OWN_I;
    end else if ((state_r == IDLE) && (i_req_s || d_req_s)) begin
      last_owner_r <= winner_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  assign last_owner_s = last_owner_r;
`else
  assign last_owner_s = OWN_I;
`endif

  // Request decode and grant selection for the IDLE state
  always_comb begin
    i_req_s  = i_pmem_read;
    d_req_s  = d_pmem_read | d_pmem_write;
    winner_s = pick_owner(i_req_s, d_req_s, last_owner_s);
  end

  // Grant FSM; the winner's command is captured at the grant edge and held until pmem_resp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= {ADDR_W{1'b0}};
      pmem_wdata <= {LINE_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (d_req_s && (winner_s == OWN_D)) begin
            state_r    <= D_BUSY;
            pmem_write <= d_pmem_write;
            pmem_read  <= d_pmem_read & ~d_pmem_write;
            pmem_addr  <= d_pmem_addr;
            pmem_wdata <= d_pmem_wdata;
          end else if (i_req_s) begin
            state_r    <= I_BUSY;
            pmem_write <= 1'b0;
            pmem_read  <= 1'b1;
            pmem_addr  <= i_pmem_addr;
          end else begin
            state_r <= IDLE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) begin
            state_r    <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion is routed to the owner in the same cycle memory responds
  always_comb begin
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = {LINE_W{1'b0}};
    d_pmem_rdata = {LINE_W{1'b0}};
    case (state_r)
      I_BUSY: begin
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_rdata;
      end
      D_BUSY: begin
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_rdata;
      end
      default: begin
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; expectations follow CACHE_ARB_RR_EN.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int check_cnt = 0;
  int fail_cnt = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int rd_cyc_cnt = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cache_mem_arbiter_chk u_chk (
    .clk(clk), .rst(rst),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .i_pmem_resp(i_pmem_resp), .d_pmem_resp(d_pmem_resp)
  );

  // Count completion pulses and read-command cycles seen at each clock edge
  always @(posedge clk) begin
    if (i_pmem_resp) i_resp_cnt <= i_resp_cnt + 1;
    if (d_pmem_resp) d_resp_cnt <= d_resp_cnt + 1;
    if (pmem_read)   rd_cyc_cnt <= rd_cyc_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: wait for a command, respond after 2 more cycles, then the owner drops its request
  task automatic serve(input logic [LW-1:0] data, output logic [AW-1:0] addr_seen,
                       output int wait_cyc);
    logic got_i;
    logic got_d;
    wait_cyc = 0;
    while (!(pmem_read || pmem_write) && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    check_val("cmd_seen", LW'(pmem_read | pmem_write), LW'(1'b1));
    addr_seen = pmem_addr;
    repeat (2) tick();
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    #1;
    got_i = i_pmem_resp;
    got_d = d_pmem_resp;
    check_val("resp_onehot", LW'(got_i ^ got_d), LW'(1'b1));
    check_val("owner_rdata", got_i ? i_pmem_rdata : d_pmem_rdata, data);
    tick();
    pmem_resp = 1'b0;
    if (got_i) i_pmem_read = 1'b0;
    if (got_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  // Both caches request in the same cycle; check grant order and the command gap
  task automatic contest(input logic [AW-1:0] first_addr, input logic [AW-1:0] second_addr);
    logic [AW-1:0] a;
    int            w;
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h00000100;
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h00000200;
    serve({8{32'h11112222}}, a, w);
    check_val("contest_first", LW'(a), LW'(first_addr));
    check_val("contest_lat", LW'(w), LW'(1));
    serve({8{32'h33334444}}, a, w);
    check_val("contest_second", LW'(a), LW'(second_addr));
    check_val("contest_gap", LW'(w), LW'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] pat;
    logic [AW-1:0] a;
    int            w;
    int            cnt0;

    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_addr = 32'h0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_addr = 32'h0; d_pmem_wdata = {LW{1'b0}};
    pmem_rdata = {LW{1'b0}}; pmem_resp = 1'b0;
    repeat (3) tick();
    check_val("rst_read", LW'(pmem_read), LW'(1'b0));
    check_val("rst_write", LW'(pmem_write), LW'(1'b0));
    check_val("rst_addr", LW'(pmem_addr), LW'(32'h0));
    check_val("rst_wdata", pmem_wdata, {LW{1'b0}});
    check_val("rst_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'(2'b00));
    rst = 1'b1;
    tick();

    // I-only read at 0x60; address changes while busy must not reach memory
    pat = {8{32'hCAFE0060}};
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h00000060;
    check_val("i_lat0", LW'(pmem_read), LW'(1'b0));
    tick();
    check_val("i_read", LW'(pmem_read), LW'(1'b1));
    check_val("i_addr", LW'(pmem_addr), LW'(32'h00000060));
    check_val("i_nowrite", LW'(pmem_write), LW'(1'b0));
    i_pmem_addr = 32'h00000AA0;
    repeat (3) tick();
    check_val("i_addr_hold", LW'(pmem_addr), LW'(32'h00000060));
    check_val("i_no_early_resp", LW'(i_pmem_resp), LW'(1'b0));
    pmem_rdata = pat;
    pmem_resp  = 1'b1;
    #1;
    check_val("i_resp", LW'(i_pmem_resp), LW'(1'b1));
    check_val("i_rdata", i_pmem_rdata, pat);
    check_val("i_d_resp_low", LW'(d_pmem_resp), LW'(1'b0));
    tick();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    check_val("i_read_clr", LW'(pmem_read), LW'(1'b0));
    check_val("i_resp_cnt", LW'(i_resp_cnt), LW'(1));
    check_val("i_dresp_cnt", LW'(d_resp_cnt), LW'(0));

    // D writeback to 0x1A0
    pat  = {8{32'hDEADBEEF}};
    cnt0 = rd_cyc_cnt;
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h000001A0;
    d_pmem_wdata = pat;
    tick();
    check_val("d_write", LW'(pmem_write), LW'(1'b1));
    check_val("d_noread", LW'(pmem_read), LW'(1'b0));
    check_val("d_addr", LW'(pmem_addr), LW'(32'h000001A0));
    check_val("d_wdata", pmem_wdata, pat);
    repeat (2) tick();
    pmem_resp = 1'b1;
    #1;
    check_val("d_resp", LW'(d_pmem_resp), LW'(1'b1));
    check_val("d_i_resp_low", LW'(i_pmem_resp), LW'(1'b0));
    tick();
    pmem_resp    = 1'b0;
    d_pmem_write = 1'b0;
    check_val("d_write_clr", LW'(pmem_write), LW'(1'b0));
    check_val("d_resp_cnt", LW'(d_resp_cnt), LW'(1));
    check_val("d_read_cycles", LW'(rd_cyc_cnt - cnt0), LW'(0));

    // Reset in the middle of a D writeback aborts it at once
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h000001A0;
    tick();
    check_val("abort_pre", LW'(pmem_write), LW'(1'b1));
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_val("abort_write", LW'(pmem_write), LW'(1'b0));
    check_val("abort_addr", LW'(pmem_addr), LW'(32'h0));
    check_val("abort_dresp", LW'(d_pmem_resp), LW'(1'b0));
    d_pmem_write = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    check_val("abort_idle", LW'({pmem_read, pmem_write}), LW'(2'b00));

    // Stray pmem_resp in IDLE produces nothing
    pmem_resp = 1'b1;
    #1;
    check_val("idle_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'(2'b00));
    tick();
    pmem_resp = 1'b0;
    check_val("idle_nocmd", LW'({pmem_read, pmem_write}), LW'(2'b00));
    check_val("abort_dresp_cnt", LW'(d_resp_cnt), LW'(1));

    // Contested grants after reset: D first both ways, since last owner resets to I
    contest(32'h00000200, 32'h00000100);
    contest(32'h00000200, 32'h00000100);

    // D-only grant, then a contest: round-robin now favours I
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h00000300;
    serve({8{32'h55556666}}, a, w);
    check_val("donly_addr", LW'(a), LW'(32'h00000300));
`ifdef CACHE_ARB_RR_EN
    contest(32'h00000100, 32'h00000200);
`else
    contest(32'h00000200, 32'h00000100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
